// File: rtl/operand_dbuf_if.sv
// Operand double-buffer bus: network word write side plus whole-frame read side.
interface operand_dbuf_if #(
    parameter int WIDTH      = 16,
    parameter int NUM_INPUTS = 8
);
    logic             w_valid;
    logic             w_ready;
    logic [WIDTH-1:0] w_data;
    logic             w_last;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] r_data [NUM_INPUTS+1];

    modport master (
        output w_valid, w_data, w_last, rd_ready,
        input  w_ready, rd_valid, r_data
    );

    modport slave (
        input  w_valid, w_data, w_last, rd_ready,
        output w_ready, rd_valid, r_data
    );
endinterface

// File: rtl/operand_dbuf.sv
// Multi-bank frame buffer collecting NUM_INPUTS operands plus a config word per frame.
// Optional macro OPERAND_DBUF_ZERO_RD_EN forces r_data to zero while no frame is presented.
module operand_dbuf #(
    parameter int WIDTH      = 16,
    parameter int NUM_INPUTS = 8,
    parameter int NUM_BANKS  = 2
) (
    input  logic          clk,
    input  logic          reset,
    operand_dbuf_if.slave bus,
    output logic          frame_done,
    output logic          frame_err
);
    localparam int WORDS = NUM_INPUTS + 1;
    localparam int IW    = $clog2(WORDS);
    localparam int PW    = $clog2(NUM_BANKS);
    localparam int CW    = $clog2(NUM_BANKS + 1);

    typedef logic [WIDTH-1:0] word_t;

    word_t         bank_q [NUM_BANKS][WORDS];
    word_t         bank_d [NUM_BANKS][WORDS];
    logic [IW-1:0] widx_q, widx_d;
    logic [PW-1:0] fill_ptr_q, fill_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] full_cnt_q, full_cnt_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          wr_xfer, rd_xfer, commit, abort;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NUM_BANKS - 1)) ? '0 : p + PW'(1);
    endfunction

    assign bus.w_ready  = ~reset & (full_cnt_q < CW'(NUM_BANKS));
    assign bus.rd_valid = ~reset & (full_cnt_q != '0);
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;

    // The config word always commits the frame; an early w_last throws the partial frame away.
    always_comb begin
        wr_xfer      = bus.w_valid & bus.w_ready;
        rd_xfer      = bus.rd_valid & bus.rd_ready;
        commit       = wr_xfer & (widx_q == IW'(NUM_INPUTS));
        abort        = wr_xfer & ~commit & bus.w_last;
        bank_d       = bank_q;
        widx_d       = widx_q;
        fill_ptr_d   = fill_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        full_cnt_d   = full_cnt_q;
        frame_done_d = commit;
        frame_err_d  = abort | (commit & ~bus.w_last);

        if (wr_xfer)
            bank_d[fill_ptr_q][widx_q] = bus.w_data;
        if (commit || abort)
            widx_d = '0;
        else if (wr_xfer)
            widx_d = widx_q + IW'(1);
        if (commit)
            fill_ptr_d = next_ptr(fill_ptr_q);
        if (rd_xfer)
            rd_ptr_d = next_ptr(rd_ptr_q);
        if (commit && !rd_xfer)
            full_cnt_d = full_cnt_q + CW'(1);
        else if (!commit && rd_xfer)
            full_cnt_d = full_cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int w = 0; w < WORDS; w++)
                    bank_q[b][w] <= '0;
            widx_q       <= '0;
            fill_ptr_q   <= '0;
            rd_ptr_q     <= '0;
            full_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            widx_q       <= widx_d;
            fill_ptr_q   <= fill_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            full_cnt_q   <= full_cnt_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
`ifdef OPERAND_DBUF_ZERO_RD_EN
            bus.r_data[i] = bus.rd_valid ? bank_q[rd_ptr_q][i] : '0;
`else
            bus.r_data[i] = bank_q[rd_ptr_q][i];
`endif
        end
    end
endmodule

// File: tb/tb_operand_dbuf.sv
// Self-checking bench for operand_dbuf: directed vector table, hand sequences, random traffic
// checked against a frame-queue reference model.
module tb_operand_dbuf;
    localparam int WIDTH = 16;
    localparam int NI    = 8;
    localparam int NB    = 2;
    localparam int NW    = NI + 1;

    typedef logic [WIDTH-1:0]          word_t;
    typedef logic [NW-1:0][WIDTH-1:0]  frame_t;

    typedef struct {
        bit    rst;
        bit    wv;
        word_t wd;
        bit    wl;
        bit    rr;
        bit    e_ready;
        bit    e_rvalid;
        bit    e_done;
        bit    e_err;
        word_t e_d0;
        word_t e_d8;
    } vec_t;

    logic clk;
    logic reset;
    logic frame_done;
    logic frame_err;

    operand_dbuf_if #(.WIDTH(WIDTH), .NUM_INPUTS(NI)) bus ();

    operand_dbuf #(.WIDTH(WIDTH), .NUM_INPUTS(NI), .NUM_BANKS(NB)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int     checks = 0;
    int     errors = 0;
    frame_t frames_q[$];
    word_t  partial_q[$];
    bit     exp_done;
    bit     exp_err;
    bit     last_xfer;
    vec_t   vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on the edge with the inputs that were stable before it.
    task automatic cycle();
        bit    ready_pre;
        bit    xfer;
        bit    rel;
        frame_t f;
        ready_pre = !reset && (frames_q.size() < NB);
        @(posedge clk);
        xfer      = bus.w_valid && ready_pre;
        rel       = !reset && bus.rd_ready && (frames_q.size() > 0);
        last_xfer = xfer;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        if (reset) begin
            frames_q.delete();
            partial_q.delete();
            last_xfer = 1'b0;
        end else begin
            if (rel)
                void'(frames_q.pop_front());
            if (xfer) begin
                partial_q.push_back(bus.w_data);
                if (partial_q.size() == NW) begin
                    for (int i = 0; i < NW; i++)
                        f[i] = partial_q[i];
                    frames_q.push_back(f);
                    partial_q.delete();
                    exp_done = 1'b1;
                    exp_err  = !bus.w_last;
                end else if (bus.w_last) begin
                    partial_q.delete();
                    exp_err = 1'b1;
                end
            end
        end
        #1;
        checkOutput();
    endtask

    task automatic checkOutput();
        int bad_idx;
        checkVal("w_ready", bus.w_ready, (!reset && frames_q.size() < NB));
        checkVal("rd_valid", bus.rd_valid, (frames_q.size() > 0));
        checkVal("frame_done", frame_done, exp_done);
        checkVal("frame_err", frame_err, exp_err);
        if (frames_q.size() > 0) begin
            bad_idx = -1;
            for (int i = NW - 1; i >= 0; i--)
                if (bus.r_data[i] !== frames_q[0][i]) bad_idx = i;
            checks++;
            if (bad_idx >= 0) begin
                errors++;
                $display("[TB] FAIL r_data[%0d] actual=%0h expected=%0h at %0t",
                         bad_idx, bus.r_data[bad_idx], frames_q[0][bad_idx], $time);
            end
        end
`ifdef OPERAND_DBUF_ZERO_RD_EN
        else begin
            bad_idx = -1;
            for (int i = 0; i < NW; i++)
                if (bus.r_data[i] !== '0) bad_idx = i;
            checks++;
            if (bad_idx >= 0) begin
                errors++;
                $display("[TB] FAIL r_data_zero[%0d] actual=%0h expected=0 at %0t",
                         bad_idx, bus.r_data[bad_idx], $time);
            end
        end
`endif
    endtask

    task automatic applyStimulus(input vec_t v);
        reset        = v.rst;
        bus.w_valid  = v.wv;
        bus.w_data   = v.wd;
        bus.w_last   = v.wl;
        bus.rd_ready = v.rr;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkVal($sformatf("vec%0d_ready", idx), bus.w_ready, v.e_ready);
        checkVal($sformatf("vec%0d_rvalid", idx), bus.rd_valid, v.e_rvalid);
        checkVal($sformatf("vec%0d_done", idx), frame_done, v.e_done);
        checkVal($sformatf("vec%0d_err", idx), frame_err, v.e_err);
        if (v.e_rvalid) begin
            checkVal($sformatf("vec%0d_d0", idx), bus.r_data[0], v.e_d0);
            checkVal($sformatf("vec%0d_d8", idx), bus.r_data[NI], v.e_d8);
        end
    endtask

    function automatic void addVec(input bit rst, input bit wv, input int wd, input bit wl,
                                   input bit rr, input bit er, input bit ev, input bit ed,
                                   input bit ee, input int d0, input int d8);
        vec_t v;
        v.rst = rst; v.wv = wv; v.wd = word_t'(wd); v.wl = wl; v.rr = rr;
        v.e_ready = er; v.e_rvalid = ev; v.e_done = ed; v.e_err = ee;
        v.e_d0 = word_t'(d0); v.e_d8 = word_t'(d8);
        vecs.push_back(v);
    endfunction

    task automatic idleInputs();
        bus.w_valid  = 1'b0;
        bus.w_data   = '0;
        bus.w_last   = 1'b0;
        bus.rd_ready = 1'b0;
    endtask

    task automatic sendWords(input int base, input int count, input bit last_at_end);
        int waited;
        for (int i = 0; i < count; i++) begin
            bus.w_valid = 1'b1;
            bus.w_data  = word_t'(base + i);
            bus.w_last  = last_at_end && (i == count - 1);
            waited = 0;
            do begin
                cycle();
                waited++;
            end while (!last_xfer && waited < 64);
            if (!last_xfer) begin
                checks++;
                errors++;
                $display("[TB] FAIL send_timeout actual=stalled expected=transfer word=%0h", base + i);
            end
        end
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
    endtask

    initial begin
        idleInputs();
        reset = 1'b1;

        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++)
            addVec(0, 1, k, k == 9, 0, 1, k == 9, k == 9, 0, 1, 9);
        addVec(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 9);
        addVec(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            addVec(0, 1, 'h10 + k, k == 3, 0, 1, 0, 0, k == 3, 0, 0);
        addVec(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++)
            addVec(0, 1, 'h20 + k, 0, 0, 1, k == 8, k == 8, k == 8, 'h20, 'h28);
        addVec(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            cycle();
            checkVector(i, vecs[i]);
        end
        idleInputs();

        // Backpressure: two frames fill both banks, the third stalls until one release.
        sendWords('h100, 9, 1);
        sendWords('h200, 9, 1);
        checkVal("s2_ready_low", bus.w_ready, 0);
        bus.w_valid = 1'b1;
        bus.w_data  = word_t'('h300);
        bus.w_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkVal("s2_stall", bus.w_ready, 0);
        end
        bus.rd_ready = 1'b1;
        cycle();
        bus.rd_ready = 1'b0;
        checkVal("s2_ready_back", bus.w_ready, 1);
        checkVal("s2_frame2", bus.r_data[0], 'h200);
        sendWords('h300, 9, 1);
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 10 && bus.rd_valid; i++)
            cycle();
        bus.rd_ready = 1'b0;
        checkVal("s2_drained", bus.rd_valid, 0);

        // Commit and release on the same edge with one frame held.
        sendWords('h400, 9, 1);
        sendWords('h500, 8, 0);
        bus.w_valid  = 1'b1;
        bus.w_data   = word_t'('h508);
        bus.w_last   = 1'b1;
        bus.rd_ready = 1'b1;
        cycle();
        idleInputs();
        checkVal("s5_done", frame_done, 1);
        checkVal("s5_rvalid", bus.rd_valid, 1);
        checkVal("s5_head", bus.r_data[0], 'h500);
        checkVal("s5_cfg", bus.r_data[NI], 'h508);
        bus.rd_ready = 1'b1;
        cycle();
        bus.rd_ready = 1'b0;
        checkVal("s5_cnt_one", bus.rd_valid, 0);

        // Reset in the middle of a frame.
        sendWords('h600, 5, 0);
        reset = 1'b1;
        cycle();
        checkVal("s6_ready_in_reset", bus.w_ready, 0);
        cycle();
        reset = 1'b0;
        cycle();
        checkVal("s6_rvalid", bus.rd_valid, 0);
        checkVal("s6_ready", bus.w_ready, 1);
        checkVal("s6_no_done", frame_done, 0);
        checkVal("s6_no_err", frame_err, 0);

        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 499) == 0);
            bus.w_valid  = ($urandom_range(0, 3) != 0);
            bus.w_data   = word_t'($urandom);
            if (partial_q.size() == NI)
                bus.w_last = ($urandom_range(0, 3) != 0);
            else
                bus.w_last = ($urandom_range(0, 15) == 0);
            bus.rd_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end
        idleInputs();
        reset = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_dbuf.md
OPERAND_DBUF -- requirements
Module: operand_dbuf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the data word width in bits.
REQ-002 The block SHALL have parameter NUM_INPUTS, default 8, the vector elements per frame; each frame is NUM_INPUTS+1 words, and the last word is config.
REQ-003 The block SHALL have parameter NUM_BANKS, default 2, the frame buffers; legal values are 2..4.
REQ-004 clk  in  1  clock; all logic is on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 w_valid  in  1  network word valid.
REQ-007 w_ready  out  1  block can accept a word.
REQ-008 w_data  in  WIDTH  network word.
REQ-009 w_last  in  1  marks the final word of a frame.
REQ-010 rd_valid  out  1  a complete frame is presented on r_data.
REQ-011 rd_ready  in  1  the vector FU consumes the presented frame.
REQ-012 r_data  out  WIDTH x (NUM_INPUTS+1) unpacked  head frame; index NUM_INPUTS is config.
REQ-013 frame_done  out  1  one-cycle pulse when a frame is committed.
REQ-014 frame_err  out  1  one-cycle pulse when w_last is misaligned with the frame length.

Function
REQ-015 A word SHALL transfer when w_valid and w_ready are both high in the same cycle.
REQ-016 Transferred words SHALL be written into the fill bank at index widx, which starts at 0 and increments per transfer.
REQ-017 The frame SHALL commit when widx==NUM_INPUTS transfers, regardless of w_last.
- On commit, the fill bank becomes full, widx returns to 0, and the fill pointer advances modulo NUM_BANKS.
- frame_done pulses on the next cycle.
REQ-018 If w_last is low at the commit transfer, the frame SHALL still commit and frame_err SHALL pulse alongside frame_done.
REQ-019 If w_last is high with widx<NUM_INPUTS, the partial frame SHALL be discarded.
- widx returns to 0 and the fill pointer is unchanged.
- frame_err pulses on the next cycle and frame_done does not pulse.
REQ-020 The block SHALL track full_cnt in the range 0..NUM_BANKS.
REQ-021 w_ready SHALL equal (full_cnt < NUM_BANKS) and SHALL not depend on w_valid.
REQ-022 rd_valid SHALL equal (full_cnt > 0).
REQ-023 r_data SHALL combinationally present every word of the head bank (read pointer) while rd_valid is high.
REQ-024 On rd_valid and rd_ready both high, the head bank SHALL be released and the read pointer SHALL advance modulo NUM_BANKS at the edge.
REQ-025 A commit and a release in the same cycle SHALL leave full_cnt unchanged; both pointers advance.
REQ-026 Latency from the commit transfer edge to rd_valid high SHALL be 1 cycle when the block was empty.
REQ-027 rd_ready asserted while rd_valid is low SHALL have no effect.
REQ-028 Bank storage SHALL not be cleared on release; only rewriting changes it.
REQ-029 Words SHALL be stored unmodified, with no width conversion.

Reset
REQ-030 While reset is high, the block SHALL hold:
- widx=0, full_cnt=0, and both pointers at 0;
- all bank words at 0;
- frame_done=0, frame_err=0, rd_valid=0;
- w_ready=0.
REQ-031 w_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-032 Reset mid-frame SHALL discard all partial and full frames, with no frame_done or frame_err pulse.

Configuration
REQ-033 With OPERAND_DBUF_ZERO_RD_EN defined, r_data SHALL be all zeros whenever rd_valid is low.
REQ-034 Without OPERAND_DBUF_ZERO_RD_EN, r_data SHALL show the bank at the read pointer whenever rd_valid is low; no gating logic is built.

Verification
REQ-035 Scenario 1: reset, then 9 words 0x0001..0x0009 with w_last on the 9th.
- frame_done pulses 1 cycle after.
- rd_valid is high, with r_data[0]=0x0001 and r_data[8]=0x0009.
REQ-036 Scenario 2: rd_ready is held low and 3 frames are sent (NUM_BANKS=2).
- w_ready drops after the 2nd commit and the 3rd frame stalls.
- One rd_ready pulse restores w_ready, and frame 2 then appears on r_data.
REQ-037 Scenario 3: w_last is sent on the 4th word.
- frame_err pulses with no frame_done, and rd_valid stays 0.
- The next 9-word frame commits normally.
REQ-038 Scenario 4: the 9th word arrives with w_last=0.
- frame_done and frame_err pulse together and the frame is readable.
REQ-039 Scenario 5: with full_cnt=1, a commit and rd_ready land in the same cycle.
- full_cnt stays 1 and r_data switches to the new frame.
REQ-040 Scenario 6: reset is asserted after 5 words.
- rd_valid=0 and w_ready=1 after release.
- r_data=0 with OPERAND_DBUF_ZERO_RD_EN defined.
